byte_to_word_packer: RTL and testbench
======================================

Name: byte_to_word_packer

Overview:
- Downstream consumer of the 8-bit registered byte pipeline. Packs consecutive bytes into BYTES-wide words, little-endian, and presents them on a valid/ready output.
- Uses a single accumulator plus one output holding register.
- Packet ends (i_last) flush partial words with a byte mask.
- Sustains 1 byte/cycle when the output is not back-pressured.

Parameters:
- DATA_WIDTH, 8, width of one input byte lane.
- BYTES, 4, bytes per output word (>=2); output width = DATA_WIDTH*BYTES.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i  in  DATA_WIDTH  input byte.
- i_vld  in  1  input byte valid.
- i_last  in  1  byte is last of packet; qualified by i_vld.
- i_rd  out  1  input ready.
- o_data  out  DATA_WIDTH*BYTES  packed word; byte k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_mask  out  BYTES  bit k = byte k valid; always contiguous from bit 0.
- o_last  out  1  word ends a packet.
- o_vld  out  1  output word valid.
- o_rd  in  1  output ready.

Behaviour:
- Reset (async, while rst=1): o_vld=0, o_data=0, o_mask=0, o_last=0, byte counter cnt=0, accumulator and accumulated mask = 0.
  - i_rd is combinational: it reads 1 in reset because o_vld=0.
  - Reset mid-packet discards the partial word; no word is emitted for it.
- Handshakes:
  - Input transfer: i_vld && i_rd.
  - Output transfer: o_vld && o_rd.
  - i_rd = !o_vld || o_rd (combinational; no dependency on i_vld).
- Counter: cnt in 0..BYTES-1, width clog2(BYTES).
- Input transfer, non-completing case (cnt != BYTES-1 and i_last=0):
  - Byte written to accumulator lane cnt; mask bit cnt set.
  - cnt <= cnt+1.
- Input transfer, completing case (cnt == BYTES-1 or i_last=1):
  - Merged word (accumulator with current byte in lane cnt) loads the output register.
  - o_mask <= accumulated mask | (1<<cnt); o_last <= i_last; o_vld <= 1.
  - cnt, accumulator and accumulated mask cleared to 0.
  - Unused lanes of o_data are 0.
- Output transfer without a completing input in the same cycle: o_vld <= 0. o_data, o_mask and o_last hold their values (do-not-care when o_vld=0).
- Simultaneous output transfer and completing input: new word replaces the old one; o_vld stays 1 with no bubble.
- Latency: a word appears on o_vld the cycle after its final byte's input transfer.
- Output stability: while o_vld=1 and o_rd=0, o_data, o_mask and o_last are stable and i_rd=0.
  - With o_vld=1, i_rd=0 stalls all input, including non-completing bytes. This is accepted: throughput loss only under back-pressure.
- i_last at cnt=BYTES-1: a single word with full mask and o_last=1.
- i_last on the first byte: mask=0b0001, o_last=1.
- No empty words are ever emitted.
- i_vld=0: no state change except output drain.

Test Plan:
- Reset, then bytes 0x11,0x22,0x33,0x44 on consecutive cycles with o_rd=1, last on 0x44 -> one cycle after 0x44: o_data=0x44332211, o_mask=0xF, o_last=1, o_vld=1 for exactly 1 cycle.
- 8 bytes 0x01..0x08 continuous, o_rd=1, no last -> words 0x04030201 then 0x08070605, each mask=0xF, o_last=0; i_rd constantly 1 (full throughput).
- Packet 0xAA,0xBB with i_last on 0xBB -> o_data=0x0000BBAA, o_mask=0x3, o_last=1; next byte 0xCC lands in lane 0.
- Back-pressure: o_rd=0 after first word 0x04030201 -> o_vld stays 1, data stable, i_rd=0 for 5 cycles, no bytes lost. Raise o_rd -> next word 0x08070605 follows correctly.
- Simultaneous drain and completion: o_vld=1, o_rd=1 in the cycle the 4th byte is accepted -> next cycle o_vld=1 with the new word; no bubble, no duplicate.
- Async reset asserted mid-cycle after 2 bytes of a word -> o_vld drops immediately without a clock edge. After release, bytes 0x10,0x20,0x30,0x40 -> o_data=0x40302010, no stale bytes.

Source files
------------

// File: rtl/byte_to_word_packer.sv
// rtl/byte_to_word_packer.sv - packs a byte stream into little-endian words with a byte mask
// One accumulator plus one output holding register; i_last flushes a partial word.
module byte_to_word_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int BYTES      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       i,
  input  logic                        i_vld,
  input  logic                        i_last,
  output logic                        i_rd,
  output logic [DATA_WIDTH*BYTES-1:0] o_data,
  output logic [BYTES-1:0]            o_mask,
  output logic                        o_last,
  output logic                        o_vld,
  input  logic                        o_rd
);

  localparam int            CW       = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BYTES - 1);

  logic [CW-1:0]               r_cnt;
  logic [DATA_WIDTH*BYTES-1:0] r_acc;
  logic [BYTES-1:0]            r_acc_mask;
  logic [DATA_WIDTH*BYTES-1:0] r_o_data;
  logic [BYTES-1:0]            r_o_mask;
  logic                        r_o_last;
  logic                        r_o_vld;

  logic                        w_in_xfer;
  logic                        w_out_xfer;
  logic                        w_complete;
  logic [DATA_WIDTH*BYTES-1:0] w_merged;
  logic [BYTES-1:0]            w_merged_mask;

  // A held word blocks every input byte, even ones that would only fill the accumulator.
  assign i_rd       = !r_o_vld || o_rd;
  assign w_in_xfer  = i_vld && i_rd;
  assign w_out_xfer = r_o_vld && o_rd;
  assign w_complete = w_in_xfer && ((r_cnt == LAST_CNT) || i_last);

  always_comb begin
    w_merged      = r_acc;
    w_merged_mask = r_acc_mask;
    for (int k = 0; k < BYTES; k++) begin
      if (r_cnt == CW'(k)) begin
        w_merged[k*DATA_WIDTH +: DATA_WIDTH] = i;
        w_merged_mask[k]                     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_acc_mask <= '0;
    end else if (w_complete) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_acc_mask <= '0;
    end else if (w_in_xfer) begin
      r_cnt      <= r_cnt + 1'b1;
      r_acc      <= w_merged;
      r_acc_mask <= w_merged_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_o_vld  <= 1'b0;
      r_o_data <= '0;
      r_o_mask <= '0;
      r_o_last <= 1'b0;
    end else if (w_complete) begin
      r_o_vld  <= 1'b1;
      r_o_data <= w_merged;
      r_o_mask <= w_merged_mask;
      r_o_last <= i_last;
    end else if (w_out_xfer) begin
      r_o_vld  <= 1'b0;
    end
  end

  assign o_data = r_o_data;
  assign o_mask = r_o_mask;
  assign o_last = r_o_last;
  assign o_vld  = r_o_vld;

endmodule

// File: tb/tb_byte_to_word_packer.sv
// tb/tb_byte_to_word_packer.sv - scoreboard bench for byte_to_word_packer
// A packet-level model predicts words; a monitor pops and compares on each output transfer.
module tb_byte_to_word_packer;

  localparam int DW = 8;
  localparam int NB = 4;

  typedef struct {
    logic [DW*NB-1:0] d;
    logic [NB-1:0]    m;
    logic             l;
  } word_t;

  logic             clk;
  logic             rst;
  logic [DW-1:0]    i;
  logic             i_vld;
  logic             i_last;
  logic             i_rd;
  logic [DW*NB-1:0] o_data;
  logic [NB-1:0]    o_mask;
  logic             o_last;
  logic             o_vld;
  logic             o_rd;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          total_stalls = 0;
  int          ord_mode = 1;
  word_t       expq[$];
  logic [DW-1:0] part[$];

  byte_to_word_packer #(.DATA_WIDTH(DW), .BYTES(NB)) dut (
    .clk(clk), .rst(rst), .i(i), .i_vld(i_vld), .i_last(i_last), .i_rd(i_rd),
    .o_data(o_data), .o_mask(o_mask), .o_last(o_last), .o_vld(o_vld), .o_rd(o_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    o_rd = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ord_mode)
        0:       o_rd = 1'b0;
        1:       o_rd = 1'b1;
        default: o_rd = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect the packet's bytes, emit a word when full or on last.
  always @(negedge clk) begin
    if (rst) begin
      part.delete();
      expq.delete();
    end else if (i_vld && i_rd) begin
      part.push_back(i);
      if (part.size() == NB || i_last) begin
        word_t w;
        w.d = '0;
        foreach (part[k]) w.d = w.d | ((DW*NB)'(part[k]) << (DW * k));
        w.m = NB'((1 << part.size()) - 1);
        w.l = i_last;
        expq.push_back(w);
        part.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && o_vld && o_rd) begin
      if (expq.size() == 0) begin
        check("unexpected_word", 64'(o_data), 64'hDEAD_0000_0000_0000);
      end else begin
        word_t e;
        e = expq.pop_front();
        check("sb_data", 64'(o_data), 64'(e.d));
        check("sb_mask", 64'(o_mask), 64'(e.m));
        check("sb_last", 64'(o_last), 64'(e.l));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_vld  = 1'b0;
    i_last = 1'b0;
  endtask

  task automatic send_byte(input logic [DW-1:0] b, input logic l);
    i      = b;
    i_vld  = 1'b1;
    i_last = l;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (i_rd) begin
        next_cycle();
        return;
      end
      total_stalls++;
      next_cycle();
    end
    check("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic drain();
    for (int c = 0; c < 200; c++) begin
      if (expq.size() == 0 && !o_vld) return;
      next_cycle();
    end
    check("drain_timeout", 64'(expq.size()), 64'(0));
  endtask

  initial begin
    int s0;
    rst    = 1'b1;
    i      = '0;
    i_vld  = 1'b0;
    i_last = 1'b0;
    #2;
    check("rst_o_vld",  64'(o_vld),  64'(0));
    check("rst_o_data", 64'(o_data), 64'(0));
    check("rst_o_mask", 64'(o_mask), 64'(0));
    check("rst_o_last", 64'(o_last), 64'(0));
    check("rst_i_rd",   64'(i_rd),   64'(1));
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // Single full packet; word visible for exactly one cycle
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    idle();
    check("t1_vld",  64'(o_vld),  64'(1));
    check("t1_data", 64'(o_data), 64'h44332211);
    check("t1_mask", 64'(o_mask), 64'hF);
    check("t1_last", 64'(o_last), 64'(1));
    next_cycle();
    check("t1_vld_drop", 64'(o_vld), 64'(0));
    drain();

    // Continuous stream at full throughput
    s0 = total_stalls;
    for (int k = 1; k <= 8; k++) send_byte(8'(k), 1'b0);
    idle();
    check("t2_no_stall", 64'(total_stalls - s0), 64'(0));
    drain();

    // Short packet, next byte restarts at lane 0
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b1);
    check("t3_data", 64'(o_data), 64'h0000BBAA);
    check("t3_mask", 64'(o_mask), 64'h3);
    check("t3_last", 64'(o_last), 64'(1));
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    send_byte(8'hEE, 1'b0);
    send_byte(8'hFF, 1'b0);
    idle();
    check("t3_lane0", 64'(o_data), 64'hFFEEDDCC);
    drain();

    // Back-pressure: held word stable and input stalled
    ord_mode = 0;
    next_cycle();
    for (int k = 1; k <= 4; k++) send_byte(8'(k), 1'b0);
    i     = 8'h05;
    i_vld = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t4_hold_vld",  64'(o_vld),  64'(1));
      check("t4_hold_data", 64'(o_data), 64'h04030201);
      check("t4_hold_i_rd", 64'(i_rd),   64'(0));
      next_cycle();
    end
    ord_mode = 1;
    for (int k = 5; k <= 8; k++) send_byte(8'(k), 1'b0);
    idle();
    check("t4_next_word", 64'(o_data), 64'h08070605);
    drain();

    // Drain and completion in the same cycle: no bubble
    for (int k = 0; k < 3; k++) begin
      send_byte(8'(8'h51 + k), 1'b1);
      check("t5_vld",  64'(o_vld),  64'(1));
      check("t5_data", 64'(o_data), 64'(8'h51 + k));
      check("t5_mask", 64'(o_mask), 64'h1);
    end
    idle();
    next_cycle();
    check("t5_vld_drop", 64'(o_vld), 64'(0));
    drain();

    // Async reset drops a held word without a clock edge
    ord_mode = 0;
    next_cycle();
    send_byte(8'h61, 1'b1);
    idle();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t6_async_vld",  64'(o_vld),  64'(0));
    check("t6_async_data", 64'(o_data), 64'(0));
    check("t6_async_i_rd", 64'(i_rd),   64'(1));
    @(negedge clk);
    next_cycle();
    rst = 1'b0;
    ord_mode = 1;

    // Reset mid-word discards the partial bytes
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    idle();
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(negedge clk);
    next_cycle();
    rst = 1'b0;
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h30, 1'b0);
    send_byte(8'h40, 1'b1);
    idle();
    check("t7_data", 64'(o_data), 64'h40302010);
    check("t7_mask", 64'(o_mask), 64'hF);
    drain();

    // Randomized traffic with random back-pressure and packet ends
    ord_mode = 2;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        next_cycle();
      end
      send_byte(8'($urandom), ($urandom_range(0, 5) == 0));
    end
    send_byte(8'($urandom), 1'b1);
    idle();
    ord_mode = 1;
    next_cycle();
    drain();
    check("end_queue_empty", 64'(expq.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
